reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised successor to the board startup-reset generator. Holds NUM_CH active-high reset outputs asserted after configuration. Releases them one at a time, in index order, after a startup delay followed by per-stage delays. Adds lock supervision, hold, soft re-sequencing and a lock-loss event counter. It sits at the top level, one instance per clock domain, and drives the resets of downstream blocks in dependency order.

Parameters:
NUM_CH, 4, number of reset outputs (>=1)
STARTUP_DLY, 65535, cycles from sequence start to release of rst_out[0] (>=1)
STAGE_DLY, 256, cycles between consecutive releases (>=1)
SYNC_STAGES, 2, synchronizer depth for lock and hold (>=2)
CNT_W, derived localparam, clog2(max(STARTUP_DLY,STAGE_DLY)+1)

Ports:
clk  in  1  domain clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
lock  in  1  asynchronous; PLL/MMCM locked indication
hold  in  1  asynchronous; freezes delay counting while high
soft_reset  in  1  synchronous single-cycle pulse; restarts the sequence
rst_out  out  NUM_CH  active-high resets; bit k released k-th
done  out  1  high once all rst_out are low
lock_lost_cnt  out  8  saturating count of lock-loss events

Behaviour:
- reset_n low: rst_out = all ones, done = 0, lock_lost_cnt = 0, sync flops = 0, state WAIT, cnt = 0, idx = 0.
- lock and hold pass through SYNC_STAGES-flop synchronizers, giving lock_s and hold_s. soft_reset is not synchronized.
- All outputs are registered, with no combinational path from inputs. A released rst_out bit changes only 1->0 until abort.
- States:
  - WAIT: cnt = 0. Go to STARTUP on the edge where lock_s = 1 and hold_s = 0.
  - STARTUP: each edge with hold_s = 0, cnt++. With hold_s = 1, cnt frozen. On an edge with cnt == STARTUP_DLY-1 and hold_s = 0: rst_out[0] <= 0, cnt <= 0, idx <= 1. If NUM_CH == 1, go to DONE with done <= 1 on that same edge; otherwise go to STAGE.
  - STAGE: counts the same way with STAGE_DLY. On terminal count: rst_out[idx] <= 0, cnt <= 0, idx++. If idx == NUM_CH-1, go to DONE with done <= 1 on that same edge.
  - DONE: hold is ignored.
- Abort: lock_s == 0 in any state except WAIT, or soft_reset == 1 in any state. The next edge sets rst_out all ones, done 0, cnt 0, idx 0, state WAIT.
  - Abort has priority over a same-edge release.
  - Simultaneous lock loss and soft_reset behave as one abort.
  - A soft_reset in WAIT is a no-op beyond holding WAIT.
- lock_lost_cnt increments by 1 on each edge where the state is not WAIT and lock_s == 0. Each excursion therefore counts once, because the state leaves to WAIT on that edge. Saturates at 255. Cleared only by reset_n.
- Timing, with reset_n released and lock = 1, hold = 0 steady: rst_out[k] falls on clk edge SYNC_STAGES+1+STARTUP_DLY+k*STAGE_DLY after the first edge following deassertion. done rises on the same edge as rst_out[NUM_CH-1] falls.
- A hold asserted for H cycles (as seen at hold_s) adds exactly H cycles to every release not yet performed.
- Mid-sequence reset_n assertion returns everything to reset values immediately (asynchronous).

Decomposition:
- Package reset_sequencer_pkg: state enum (WAIT, STARTUP, STAGE, DONE) and the lock_lost_cnt width constant (8).
- Sub-module bit_sync: SYNC_STAGES-deep single-bit synchronizer with async active-low clear to 0. Instantiated twice, for lock and hold.

Test Plan:
All scenarios use NUM_CH=3, STARTUP_DLY=10, STAGE_DLY=4, SYNC_STAGES=2.
- Nominal: lock = 1, hold = 0 from reset release -> rst_out[0] falls at edge 13, rst_out[1] at 17, rst_out[2] and done at 21. lock_lost_cnt = 0.
- Hold: hold high for 5 cycles at edge 8 -> all releases shift by 5 (18/22/26). A hold pulse applied after done causes no change.
- Lock loss mid-sequence: lock drops after rst_out[0] released -> 3 cycles later (2 sync edges + 1) rst_out = 3'b111, done = 0, lock_lost_cnt = 1. Lock restored -> full sequence repeats with the same relative timing.
- soft_reset while in DONE -> next edge rst_out = 3'b111, done = 0. Sequence repeats with rst_out[0] falling 1+10 edges after re-entry to STARTUP. lock_lost_cnt is unchanged.
- Collision: soft_reset on the edge where rst_out[1] would release -> rst_out[1] stays 1, all bits return to 1. Then NUM_CH=1 build -> done and rst_out[0] fall on the same edge, 13.
- Saturation and async reset: 300 lock-loss excursions -> lock_lost_cnt = 255. Asserting reset_n mid-STAGE -> rst_out = all ones and counter = 0 with no clock edge.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared constants for the reset sequencer: FSM state encodings and counter widths.
package reset_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_STARTUP = 2'd1;
  localparam logic [1:0] ST_STAGE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// Multi-flop single-bit synchronizer; clears to 0 while reset is asserted.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input in at the LSB.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_CH active-high resets one at a time after lock, with hold,
// soft re-sequencing and a saturating lock-loss counter.
//
// state   | meaning
// WAIT    | all resets asserted, waiting for lock_s=1 and hold_s=0
// STARTUP | counting the startup delay before releasing rst_out[0]
// STAGE   | counting the per-stage delay before releasing rst_out[idx]
// DONE    | every reset released; hold ignored
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int STARTUP_DLY = 65535,
  parameter int STAGE_DLY   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lock,
  input  logic                  hold,
  input  logic                  soft_reset,
  output logic [NUM_CH-1:0]     rst_out,
  output logic                  done,
  output logic [LOCK_CNT_W-1:0] lock_lost_cnt
);

  localparam int MAX_DLY = (STARTUP_DLY > STAGE_DLY) ? STARTUP_DLY : STAGE_DLY;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  logic lock_s;
  logic hold_s;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CH-1:0]       rst_q, rst_d;
  logic                    done_q, done_d;
  logic [LOCK_CNT_W-1:0]   llc_q, llc_d;
  logic                    lock_loss;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (lock),
    .q     (lock_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_hold_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (hold),
    .q     (hold_s)
  );

  // Next-state logic: abort takes precedence over any release on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    done_d    = done_q;
    llc_d     = llc_q;
    lock_loss = (state_q != ST_WAIT) && !lock_s;

    if (lock_loss && (llc_q != '1)) llc_d = llc_q + 1'b1;

    if (soft_reset || lock_loss) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_d = '0;
          if (lock_s && !hold_s) state_d = ST_STARTUP;
        end
        ST_STARTUP: begin
          if (!hold_s) begin
            if (cnt_q == CNT_W'(STARTUP_DLY - 1)) begin
              rst_d[0] = 1'b0;
              cnt_d    = '0;
              idx_d    = IDX_W'(1);
              if (NUM_CH == 1) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_STAGE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_STAGE: begin
          if (!hold_s) begin
            if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
              end
              cnt_d = '0;
              if (idx_q == IDX_W'(NUM_CH - 1)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      llc_q   <= llc_d;
    end
  end

  assign rst_out       = rst_q;
  assign done          = done_q;
  assign lock_lost_cnt = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output events (edge, value)
// are queued per scenario and matched against each observed output change.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lock = 1'b1;
  logic       hold = 1'b0;
  logic       soft_reset = 1'b0;
  logic [2:0] rst_out;
  logic       done;
  logic [7:0] llc;
  logic [0:0] rst_out1;
  logic       done1;
  logic [7:0] llc1;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(3), .STARTUP_DLY(10), .STAGE_DLY(4), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lock          (lock),
    .hold          (hold),
    .soft_reset    (soft_reset),
    .rst_out       (rst_out),
    .done          (done),
    .lock_lost_cnt (llc)
  );

  reset_sequencer #(.NUM_CH(1), .STARTUP_DLY(10), .STAGE_DLY(4), .SYNC_STAGES(2)) dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .lock          (lock),
    .hold          (hold),
    .soft_reset    (soft_reset),
    .rst_out       (rst_out1),
    .done          (done1),
    .lock_lost_cnt (llc1)
  );

  typedef struct {
    int         edge_n;
    logic [2:0] rst;
    logic       dn;
    logic [7:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edge_n = 0;
  logic        mon_en = 1'b1;
  logic [11:0] prev_obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic push(input int e, input logic [2:0] r, input logic d, input logic [7:0] c);
    exp_t x;
    x.edge_n = e;
    x.rst    = r;
    x.dn     = d;
    x.cnt    = c;
    sb_q.push_back(x);
  endtask

  task automatic step();
    exp_t        e;
    logic [11:0] cur;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    cur = {rst_out, done, llc};
    if (mon_en && (cur !== prev_obs)) begin
      if (sb_q.size() == 0) begin
        check("spurious_change", cur, prev_obs);
      end else begin
        e = sb_q.pop_front();
        check("event_edge", edge_n, e.edge_n);
        check("rst_out", rst_out, e.rst);
        check("done", done, e.dn);
        check("lock_lost_cnt", llc, e.cnt);
      end
    end
    prev_obs = cur;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    soft_reset = 1'b0;
    hold       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rst_out", rst_out, 3'b111);
    check("rst_done", done, 1'b0);
    check("rst_llc", llc, 8'd0);
    check("rst_ch1_rst_out", rst_out1, 1'b1);
    check("rst_ch1_done", done1, 1'b0);
    reset_n  = 1'b1;
    edge_n   = 0;
    prev_obs = {rst_out, done, llc};
  endtask

  initial begin
    // Nominal sequence, plus the single-channel build alongside.
    lock = 1'b1;
    do_reset();
    push(13, 3'b110, 1'b0, 8'd0);
    push(17, 3'b100, 1'b0, 8'd0);
    push(21, 3'b000, 1'b1, 8'd0);
    run_to(12);
    check("ch1_rst_before", rst_out1, 1'b1);
    check("ch1_done_before", done1, 1'b0);
    run_to(13);
    check("ch1_rst_at13", rst_out1, 1'b0);
    check("ch1_done_at13", done1, 1'b1);
    run_to(30);
    check("nominal_sb_empty", sb_q.size(), 0);

    // Hold for 5 synchronized cycles starting at edge 8.
    do_reset();
    push(18, 3'b110, 1'b0, 8'd0);
    push(22, 3'b100, 1'b0, 8'd0);
    push(26, 3'b000, 1'b1, 8'd0);
    run_to(7);
    hold = 1'b1;
    run_to(12);
    hold = 1'b0;
    run_to(30);
    check("hold_sb_empty", sb_q.size(), 0);
    hold = 1'b1;
    run_to(35);
    hold = 1'b0;
    run_to(45);
    check("hold_after_done_rst", rst_out, 3'b000);
    check("hold_after_done_done", done, 1'b1);

    // Lock loss after the first release, then recovery.
    do_reset();
    push(13, 3'b110, 1'b0, 8'd0);
    run_to(13);
    lock = 1'b0;
    push(16, 3'b111, 1'b0, 8'd1);
    run_to(20);
    lock = 1'b1;
    push(33, 3'b110, 1'b0, 8'd1);
    push(37, 3'b100, 1'b0, 8'd1);
    push(41, 3'b000, 1'b1, 8'd1);
    run_to(45);
    check("lockloss_sb_empty", sb_q.size(), 0);

    // Soft reset in DONE, then a soft reset colliding with the rst_out[1] release.
    push(46, 3'b111, 1'b0, 8'd1);
    push(57, 3'b110, 1'b0, 8'd1);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    run_to(60);
    push(61, 3'b111, 1'b0, 8'd1);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    push(72, 3'b110, 1'b0, 8'd1);
    push(76, 3'b100, 1'b0, 8'd1);
    push(80, 3'b000, 1'b1, 8'd1);
    run_to(85);
    check("soft_sb_empty", sb_q.size(), 0);

    // 300 lock-loss excursions: counter starts at 1 and must saturate.
    mon_en = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      lock = 1'b0;
      repeat (3) step();
      lock = 1'b1;
      repeat (3) step();
      if (i == 100) check("llc_after_100", llc, 8'd101);
    end
    check("llc_saturated", llc, 8'd255);

    // Into STAGE, then async reset with no clock edge.
    repeat (12) step();
    check("stage_reached", rst_out, 3'b110);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", rst_out, 3'b111);
    check("async_done", done, 1'b0);
    check("async_llc", llc, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
